// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift_deserializer receive path.
// Optional feature macro used across this slice: PARITY_CHECK_EN.
package shift_deser_pkg;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PARITY  = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial-in / parallel-out bus of the shift_deserializer.
// The slave modport is the deserializer's view, the master modport is the link/sink view.
interface shift_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             s_din;
  logic             s_valid;
  logic             lsb_first;
  logic             flush;
  logic [WIDTH-1:0] p_dout;
  logic             p_valid;
  logic             p_ready;
  logic             par_err;

  modport master (
    output s_din, s_valid, lsb_first, flush, p_ready,
    input  p_dout, p_valid, par_err
  );

  modport slave (
    input  s_din, s_valid, lsb_first, flush, p_ready,
    output p_dout, p_valid, par_err
  );

endinterface

// File: rtl/shift_deserializer_out_slot.sv
// One-entry valid/ready output register for assembled words; flags words that arrive while full.
// With PARITY_CHECK_EN defined the parity error bit travels with the word.
module deser_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic [WIDTH-1:0] word,
`ifdef PARITY_CHECK_EN
  input  logic             par_in,
  output logic             par_err,
`endif
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_dout,
  output logic             p_valid,
  output logic             ovr_pulse
);

  logic accept;

  // The slot can take a word when empty or when its current word leaves this cycle.
  assign accept    = !p_valid || p_ready;
  assign ovr_pulse = commit && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_dout  <= '0;
      p_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err <= 1'b0;
`endif
    end else if (commit && accept) begin
      p_dout  <= word;
      p_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
      par_err <= par_in;
`endif
    end else if (p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first with sticky overrun.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and report par_err.
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_deserializer_if.slave bus,
  input  logic                clr_ovr,
  output logic                ovr
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] bit_cnt;
  logic             dir_q;
  logic             dir_eff;
  logic             collect;
  logic             commit;
  logic             ovr_pulse;
`ifdef PARITY_CHECK_EN
  logic             par_bit;
`endif

  // The first bit of a frame already shifts in the direction it latches.
  assign dir_eff = (bit_cnt == '0) ? bus.lsb_first : dir_q;
  assign collect = bus.s_valid && !bus.flush && (state == ST_COLLECT);

  always_comb begin
    sh_next = sh;
    if (dir_eff == DIR_LSB_FIRST) begin
      sh_next = {bus.s_din, sh[WIDTH-1:1]};
    end else begin
      sh_next = {sh[WIDTH-2:0], bus.s_din};
    end
  end

`ifdef PARITY_CHECK_EN
  assign commit  = bus.s_valid && !bus.flush && (state == ST_PARITY);
  assign word    = sh;
  assign par_bit = ^{sh, bus.s_din};
`else
  assign commit  = collect && (bit_cnt == LAST_IDX);
  assign word    = sh_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bit_cnt <= '0;
      dir_q   <= DIR_MSB_FIRST;
      state   <= ST_COLLECT;
    end else if (bus.flush) begin
      sh      <= '0;
      bit_cnt <= '0;
      state   <= ST_COLLECT;
    end else if (bus.s_valid) begin
      if (state == ST_COLLECT) begin
        sh <= sh_next;
        if (bit_cnt == '0) begin
          dir_q <= bus.lsb_first;
        end
        if (bit_cnt == LAST_IDX) begin
          bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
          state   <= ST_PARITY;
`endif
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else begin
        state <= ST_COLLECT;
      end
    end
  end

  // A word dropped in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (ovr_pulse) begin
      ovr <= 1'b1;
    end else if (clr_ovr) begin
      ovr <= 1'b0;
    end
  end

  deser_out_slot #(
    .WIDTH (WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .word      (word),
`ifdef PARITY_CHECK_EN
    .par_in    (par_bit),
    .par_err   (bus.par_err),
`endif
    .p_ready   (bus.p_ready),
    .p_dout    (bus.p_dout),
    .p_valid   (bus.p_valid),
    .ovr_pulse (ovr_pulse)
  );

`ifndef PARITY_CHECK_EN
  assign bus.par_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed testbench for shift_deserializer; parity scenarios run when PARITY_CHECK_EN is defined.
module tb_shift_deserializer;

  localparam int WIDTH = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clr_ovr = 1'b0;
  logic ovr;
  int   n_checks = 0;
  int   n_fails  = 0;

  shift_deserializer_if #(.WIDTH(WIDTH)) bus ();

  shift_deserializer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_ovr (clr_ovr),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; presents one bit for the next rising edge, then idles gap cycles.
  task automatic applyStimulus(input logic b, input int gap);
    bus.s_valid = 1'b1;
    bus.s_din   = b;
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // bits[3] goes on the wire first; returns at the falling edge after the final bit was sampled.
  task automatic sendFrame(input logic [3:0] bits, input logic lsb, input int gap,
                           input logic toggle_mid, input logic par_flip, input logic ready_last);
    logic last;
    bus.lsb_first = lsb;
    for (int i = 3; i >= 0; i--) begin
`ifdef PARITY_CHECK_EN
      last = 1'b0;
`else
      last = (i == 0);
`endif
      if (last && ready_last) bus.p_ready = 1'b1;
      applyStimulus(bits[i], last ? 0 : gap);
      if (i == 3 && toggle_mid) bus.lsb_first = ~lsb;
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) bus.p_ready = 1'b1;
    applyStimulus((^bits) ^ par_flip, 0);
`else
    last = par_flip;
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.s_din     = 1'b0;
    bus.s_valid   = 1'b0;
    bus.lsb_first = 1'b0;
    bus.flush     = 1'b0;
    bus.p_ready   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_p_dout",  32'(bus.p_dout), 32'h0);
    checkOutput("reset_p_valid", 32'(bus.p_valid), 32'h0);
    checkOutput("reset_ovr",     32'(ovr), 32'h0);
    checkOutput("reset_par_err", 32'(bus.par_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] MSB-first frame 1,1,0,1");
    bus.p_ready = 1'b1;
    sendFrame(4'b1101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("msb_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("msb_dout",  32'(bus.p_dout), 32'hD);
    @(negedge clk);
    checkOutput("msb_valid_drop", 32'(bus.p_valid), 32'h0);

    $display("[TB] LSB-first frame 1,0,1,1 with and without mid-frame toggle");
    sendFrame(4'b1011, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("lsb_dout", 32'(bus.p_dout), 32'hD);
    @(negedge clk);
    sendFrame(4'b1011, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    checkOutput("lsb_toggle_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("lsb_toggle_dout",  32'(bus.p_dout), 32'hD);
    @(negedge clk);

    $display("[TB] overrun with p_ready low");
    bus.p_ready = 1'b0;
    sendFrame(4'b1101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_first_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("ovr_first_flag",  32'(ovr), 32'h0);
    sendFrame(4'b0110, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_hold_dout", 32'(bus.p_dout), 32'hD);
    checkOutput("ovr_set",       32'(ovr), 32'h1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    checkOutput("ovr_cleared", 32'(ovr), 32'h0);
    clr_ovr = 1'b1;
    sendFrame(4'b0011, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    clr_ovr = 1'b0;
    checkOutput("ovr_beats_clear", 32'(ovr), 32'h1);
    checkOutput("ovr_hold_dout2",  32'(bus.p_dout), 32'hD);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    bus.p_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_drain_valid", 32'(bus.p_valid), 32'h0);
    checkOutput("ovr_drain_dout",  32'(bus.p_dout), 32'hD);
    checkOutput("ovr_after_clear", 32'(ovr), 32'h0);

    $display("[TB] sparse bits with flush");
    applyStimulus(1'b1, 2);
    applyStimulus(1'b1, 2);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    sendFrame(4'b0011, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("flush_dout",  32'(bus.p_dout), 32'h3);
    @(negedge clk);
    bus.flush = 1'b1;
    applyStimulus(1'b1, 0);
    bus.flush = 1'b0;
    checkOutput("flush_keeps_dout", 32'(bus.p_dout), 32'h3);
    sendFrame(4'b0110, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_bit_ignored_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("flush_bit_ignored_dout",  32'(bus.p_dout), 32'h6);
    @(negedge clk);

`ifdef PARITY_CHECK_EN
    $display("[TB] flush while waiting for parity bit");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("par_flush_no_valid", 32'(bus.p_valid), 32'h0);
    sendFrame(4'b0101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("par_flush_dout", 32'(bus.p_dout), 32'h5);
    @(negedge clk);
`endif

    $display("[TB] asynchronous reset mid-frame");
    bus.p_ready = 1'b0;
    sendFrame(4'b1111, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    sendFrame(4'b0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_ovr", 32'(ovr), 32'h1);
    applyStimulus(1'b1, 0);
    applyStimulus(1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_p_valid", 32'(bus.p_valid), 32'h0);
    checkOutput("async_p_dout",  32'(bus.p_dout), 32'h0);
    checkOutput("async_ovr",     32'(ovr), 32'h0);
    checkOutput("async_par_err", 32'(bus.par_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.p_ready = 1'b1;
    sendFrame(4'b1001, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_valid", 32'(bus.p_valid), 32'h1);
    checkOutput("post_reset_dout",  32'(bus.p_dout), 32'h9);
    @(negedge clk);

    $display("[TB] back-to-back commit on a transfer cycle");
    bus.p_ready = 1'b0;
    sendFrame(4'b1010, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_first_dout", 32'(bus.p_dout), 32'hA);
    sendFrame(4'b0101, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_valid_kept", 32'(bus.p_valid), 32'h1);
    checkOutput("b2b_new_dout",   32'(bus.p_dout), 32'h5);
    checkOutput("b2b_no_ovr",     32'(ovr), 32'h0);
    @(negedge clk);
    checkOutput("b2b_valid_drop", 32'(bus.p_valid), 32'h0);

`ifdef PARITY_CHECK_EN
    $display("[TB] parity check");
    sendFrame(4'b1101, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("par_good_dout", 32'(bus.p_dout), 32'hD);
    checkOutput("par_good_err",  32'(bus.par_err), 32'h0);
    @(negedge clk);
    sendFrame(4'b1101, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("par_bad_dout", 32'(bus.p_dout), 32'hD);
    checkOutput("par_bad_err",  32'(bus.par_err), 32'h1);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
